writeback_arbiter: RTL and testbench

Merges completed results from two execution sources (the single-cycle ALU path and the multi-cycle load/mul-div path) into the register file's single write port. Each source has a small FIFO with valid/ready flow control. A round-robin arbiter drains one entry per cycle into registered `write_enable`/`write_addr`/`write_data` outputs. Two combinational query ports report whether a register still has a result queued, for issue-stage hazard checks.

---
 rtl/wb_pkg.sv | 17 +
 rtl/wb_fifo.sv | 71 +++++++
 rtl/writeback_arbiter.sv | 120 ++++++++++++
 tb/tb_writeback_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback arbiter and its source FIFOs.
package wb_pkg;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    localparam logic WB_SRC_A = 1'b0;
    localparam logic WB_SRC_B = 1'b1;

    // True when a live entry targets the queried register.
    function automatic logic wb_hit(input logic [4:0] addr, input wb_entry_t e, input logic v);
        return v && (e.rd == addr);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order result FIFO for one execution source; exposes its storage and
// per-entry valid bits so the top level can run pending-register compares.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        i_push,
    input  wb_entry_t                   i_push_entry,
    input  logic                        i_pop,
    output wb_entry_t                   o_head,
    output logic                        o_empty,
    output logic                        o_full,
    output wb_entry_t [DEPTH-1:0]       o_entries,
    output logic      [DEPTH-1:0]       o_valid
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t [DEPTH-1:0] r_mem;
    logic      [DEPTH-1:0] r_vld;
    logic      [AW-1:0]    r_wr_ptr;
    logic      [AW-1:0]    r_rd_ptr;
    logic      [AW:0]      r_count;

    logic w_push;
    logic w_pop;

    // Full/empty come from the registered count only, so ready never
    // depends combinationally on the drain side.
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    assign o_head    = r_mem[r_rd_ptr];
    assign o_entries = r_mem;
    assign o_valid   = r_vld;

    // Pointer, occupancy and per-slot valid tracking; reset discards everything.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_vld    <= '0;
        end else begin
            if (w_pop) begin
                r_rd_ptr        <= r_rd_ptr + AW'(1);
                r_vld[r_rd_ptr] <= 1'b0;
            end
            if (w_push) begin
                r_wr_ptr        <= r_wr_ptr + AW'(1);
                r_vld[r_wr_ptr] <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage; contents only matter where the valid bit is set.
    always_ff @(posedge clock) begin
        if (reset_n && w_push) r_mem[r_wr_ptr] <= i_push_entry;
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU (A) and LSU/MUL-DIV (B) results into the single register-file
// write port with round-robin arbitration, and answers issue-stage
// "is this register still pending?" queries.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_rd,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_rd,
    input  logic [31:0] b_data,
    output logic        write_enable,
    output logic [4:0]  write_addr,
    output logic [31:0] write_data,
    input  logic [4:0]  query_addr1,
    input  logic [4:0]  query_addr2,
    output logic        query_pending1,
    output logic        query_pending2
);

    wb_entry_t             w_a_head, w_b_head;
    logic                  w_a_empty, w_b_empty, w_a_full, w_b_full;
    wb_entry_t [DEPTH-1:0] w_a_entries, w_b_entries;
    logic      [DEPTH-1:0] w_a_vld, w_b_vld;
    logic                  w_a_push, w_b_push;
    logic                  w_gnt_a, w_gnt_b;
    logic                  w_hit1, w_hit2;

    logic                  r_last_grant;
    logic                  r_we;
    logic [4:0]            r_waddr;
    logic [31:0]           r_wdata;

    assign a_ready = !w_a_full;
    assign b_ready = !w_b_full;

    // x0 writes complete the handshake but are never queued.
    assign w_a_push = a_valid && a_ready && (a_rd != 5'd0);
    assign w_b_push = b_valid && b_ready && (b_rd != 5'd0);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_push       (w_a_push),
        .i_push_entry ('{rd: a_rd, data: a_data}),
        .i_pop        (w_gnt_a),
        .o_head       (w_a_head),
        .o_empty      (w_a_empty),
        .o_full       (w_a_full),
        .o_entries    (w_a_entries),
        .o_valid      (w_a_vld)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_push       (w_b_push),
        .i_push_entry ('{rd: b_rd, data: b_data}),
        .i_pop        (w_gnt_b),
        .o_head       (w_b_head),
        .o_empty      (w_b_empty),
        .o_full       (w_b_full),
        .o_entries    (w_b_entries),
        .o_valid      (w_b_vld)
    );

    // Round robin: A wins when alone or when B was served last.
    assign w_gnt_a = !w_a_empty && (w_b_empty || (r_last_grant == WB_SRC_B));
    assign w_gnt_b = !w_b_empty && !w_gnt_a;

    // Output register and grant history; address/data hold on idle cycles.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_last_grant <= WB_SRC_B;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
        end else if (w_gnt_a) begin
            r_last_grant <= WB_SRC_A;
            r_we         <= 1'b1;
            r_waddr      <= w_a_head.rd;
            r_wdata      <= w_a_head.data;
        end else if (w_gnt_b) begin
            r_last_grant <= WB_SRC_B;
            r_we         <= 1'b1;
            r_waddr      <= w_b_head.rd;
            r_wdata      <= w_b_head.data;
        end else begin
            r_we         <= 1'b0;
        end
    end

    assign write_enable = r_we;
    assign write_addr   = r_waddr;
    assign write_data   = r_wdata;

    // Scan every live queue slot of both sources for each query register.
    always_comb begin
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_hit1 = w_hit1 | wb_hit(query_addr1, w_a_entries[i], w_a_vld[i])
                            | wb_hit(query_addr1, w_b_entries[i], w_b_vld[i]);
            w_hit2 = w_hit2 | wb_hit(query_addr2, w_a_entries[i], w_a_vld[i])
                            | wb_hit(query_addr2, w_b_entries[i], w_b_vld[i]);
        end
    end

    // The in-flight write still counts as pending until the register file takes it.
    assign query_pending1 = (query_addr1 != 5'd0) && (w_hit1 || (r_we && (r_waddr == query_addr1)));
    assign query_pending2 = (query_addr2 != 5'd0) && (w_hit2 || (r_we && (r_waddr == query_addr2)));

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic, all
// compared each cycle against a queue-based reference model.
module tb_writeback_arbiter;
    import wb_pkg::*;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [4:0]  a_rd = '0, b_rd = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic [4:0]  query_addr1 = '0, query_addr2 = '0;
    logic        a_ready, b_ready, write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        query_pending1, query_pending2;

    writeback_arbiter #(.DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .a_valid        (a_valid),
        .a_ready        (a_ready),
        .a_rd           (a_rd),
        .a_data         (a_data),
        .b_valid        (b_valid),
        .b_ready        (b_ready),
        .b_rd           (b_rd),
        .b_data         (b_data),
        .write_enable   (write_enable),
        .write_addr     (write_addr),
        .write_data     (write_data),
        .query_addr1    (query_addr1),
        .query_addr2    (query_addr2),
        .query_pending1 (query_pending1),
        .query_pending2 (query_pending2)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Reference model: two queues, a "who was served last" bit, output register.
    wb_entry_t   qa[$], qb[$];
    bit          m_known = 0;
    bit          m_last_b;
    bit          m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    int          cyc = 0;
    int          wlog[$];
    int          wcyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_pending(input logic [4:0] addr);
        if (addr == 0) return 0;
        foreach (qa[i]) if (qa[i].rd == addr) return 1;
        foreach (qb[i]) if (qb[i].rd == addr) return 1;
        return m_we && (m_wa == addr);
    endfunction

    // One clock: compare DUT to model, then advance both across the edge.
    task automatic cycle();
        bit acc_a, acc_b, ga, gb;
        wb_entry_t e;
        #1;
        if (m_known) begin
            chk("a_ready", a_ready, (qa.size() < DEPTH));
            chk("b_ready", b_ready, (qb.size() < DEPTH));
            chk("write_enable", write_enable, m_we);
            chk("write_addr", write_addr, m_wa);
            chk("write_data", write_data, m_wd);
            chk("query_pending1", query_pending1, m_pending(query_addr1));
            chk("query_pending2", query_pending2, m_pending(query_addr2));
        end
        if (write_enable === 1'b1) begin
            wlog.push_back(int'(write_addr));
            wcyc.push_back(cyc);
        end
        acc_a = a_valid && (qa.size() < DEPTH);
        acc_b = b_valid && (qb.size() < DEPTH);
        ga = (qa.size() > 0) && ((qb.size() == 0) || m_last_b);
        gb = (qb.size() > 0) && !ga;
        @(posedge clock);
        cyc++;
        if (!reset_n) begin
            qa.delete();
            qb.delete();
            m_last_b = 1;
            m_we = 0;
            m_wa = '0;
            m_wd = '0;
            m_known = 1;
        end else begin
            if (ga) begin
                e = qa.pop_front();
                m_we = 1; m_wa = e.rd; m_wd = e.data; m_last_b = 0;
            end else if (gb) begin
                e = qb.pop_front();
                m_we = 1; m_wa = e.rd; m_wd = e.data; m_last_b = 1;
            end else begin
                m_we = 0;
            end
            if (acc_a && a_rd != 0) qa.push_back('{rd: a_rd, data: a_data});
            if (acc_b && b_rd != 0) qb.push_back('{rd: b_rd, data: b_data});
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit r, saw_full;
        int k, guard, na;
        int exp_order[6];
        exp_order = '{1, 11, 2, 12, 3, 13};

        // Reset with a pushing source: pushes must be dropped.
        reset_n = 0; a_valid = 1; a_rd = 5'd9; a_data = 32'h55;
        cycle(); cycle();
        reset_n = 1; a_valid = 0;
        #1;
        chk("rst_we", write_enable, 0);
        chk("rst_waddr", write_addr, 0);
        chk("rst_wdata", write_data, 0);
        chk("rst_a_ready", a_ready, 1);
        wlog.delete(); wcyc.delete();
        repeat (4) cycle();
        chk("rst_no_write", wlog.size(), 0);

        // Single-result latency.
        a_valid = 1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
        cycle();
        a_valid = 0;
        chk("lat_edgeN_we", write_enable, 0);
        cycle();
        chk("lat_we", write_enable, 1);
        chk("lat_addr", write_addr, 5);
        chk("lat_data", write_data, 32'hDEADBEEF);
        cycle();
        chk("lat_we_off", write_enable, 0);

        // Contention from a fresh reset: A wins first, then strict alternation.
        reset_n = 0; cycle(); reset_n = 1;
        wlog.delete(); wcyc.delete();
        for (int i = 0; i < 3; i++) begin
            a_valid = 1; a_rd = 5'(i + 1);  a_data = 32'(100 + i);
            b_valid = 1; b_rd = 5'(i + 11); b_data = 32'(200 + i);
            cycle();
        end
        a_valid = 0; b_valid = 0;
        repeat (10) cycle();
        chk("cont_count", wlog.size(), 6);
        for (int i = 0; i < 6 && i < wlog.size(); i++) begin
            chk("cont_order", wlog[i], exp_order[i]);
            chk("cont_consecutive", wcyc[i] - wcyc[0], i);
        end

        // x0 filtering.
        wlog.delete(); wcyc.delete();
        query_addr1 = 0;
        b_valid = 1; b_rd = 5'd0; b_data = 32'h1234;
        #1;
        chk("x0_b_ready", b_ready, 1);
        cycle();
        b_valid = 0;
        chk("x0_pending", query_pending1, 0);
        repeat (3) cycle();
        chk("x0_no_write", wlog.size(), 0);

        // Backpressure: B keeps contending so A fills; nothing lost or duplicated.
        wlog.delete(); wcyc.delete();
        k = 1; saw_full = 0; guard = 0;
        while (k <= 10 && guard < 80) begin
            a_valid = 1; a_rd = 5'(20 + k); a_data = 32'(k);
            b_valid = 1; b_rd = 5'((guard % 8) + 1); b_data = 32'(guard);
            #1;
            r = a_ready;
            if (!r) saw_full = 1;
            cycle();
            if (r) k++;
            guard++;
        end
        a_valid = 0; b_valid = 0;
        repeat (30) cycle();
        chk("bp_all_accepted", k, 11);
        chk("bp_saw_not_ready", saw_full, 1);
        na = 0;
        foreach (wlog[i]) if (wlog[i] > 20) begin
            chk("bp_a_order", wlog[i], 21 + na);
            na++;
        end
        chk("bp_a_count", na, 10);

        // Pending query window for rd=7.
        reset_n = 0; cycle(); reset_n = 1;
        query_addr1 = 5'd7; query_addr2 = 5'd8;
        #1;
        chk("pend_before", query_pending1, 0);
        a_valid = 1; a_rd = 5'd7; a_data = 32'h77;
        cycle();
        a_valid = 0;
        chk("pend_queued", query_pending1, 1);
        chk("pend_other_q", query_pending2, 0);
        cycle();
        chk("pend_we_cycle", write_enable, 1);
        chk("pend_inflight", query_pending1, 1);
        cycle();
        chk("pend_cleared", query_pending1, 0);
        chk("pend_other_end", query_pending2, 0);

        // Randomized traffic, including occasional mid-stream resets.
        for (int i = 0; i < 600; i++) begin
            reset_n     = ($urandom_range(0, 63) != 0);
            a_valid     = $urandom_range(0, 1);
            b_valid     = ($urandom_range(0, 2) != 0);
            a_rd        = 5'($urandom_range(0, 9));
            b_rd        = 5'($urandom_range(0, 9));
            a_data      = $urandom;
            b_data      = $urandom;
            query_addr1 = 5'($urandom_range(0, 9));
            query_addr2 = 5'($urandom_range(0, 9));
            cycle();
        end
        reset_n = 1; a_valid = 0; b_valid = 0;
        repeat (12) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
